// File: rtl/sdram_arbiter.sv
// Two-port (I-cache / D-cache) arbiter in front of a single SDRAM controller bus.
// Define SDRAM_ARB_ROUND_ROBIN_EN for round-robin tie breaking; otherwise D wins ties.
module sdram_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_we,
    input  logic              i_start,
    output logic [DATA_W-1:0] i_q,
    output logic              i_done,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_data,
    input  logic              d_we,
    input  logic              d_start,
    output logic [DATA_W-1:0] d_q,
    output logic              d_done,
    output logic [ADDR_W-1:0] sdc_addr,
    output logic [DATA_W-1:0] sdc_data,
    output logic              sdc_we,
    output logic              sdc_start,
    input  logic [DATA_W-1:0] sdc_q,
    input  logic              sdc_done
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RELEASE} state_t;

    state_t            r_state, w_state_nxt;
    logic              r_owner, w_owner_nxt;       // 0 = I, 1 = D
    logic              r_rr_last, w_rr_nxt;        // last port served, same encoding
    logic [ADDR_W-1:0] r_sdc_addr, w_addr_nxt;
    logic [DATA_W-1:0] r_sdc_data, w_data_nxt;
    logic              r_sdc_we, w_we_nxt;
    logic              r_sdc_start, w_start_nxt;
    logic [DATA_W-1:0] r_i_q, w_iq_nxt;
    logic [DATA_W-1:0] r_d_q, w_dq_nxt;
    logic              r_i_done, w_idone_nxt;
    logic              r_d_done, w_ddone_nxt;
    logic              w_grant_d;

    always_comb begin
        w_grant_d = d_start;
        if (i_start && d_start) begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
            w_grant_d = ~r_rr_last;
`else
            w_grant_d = 1'b1;
`endif
        end
    end

`ifndef SDRAM_ARB_ROUND_ROBIN_EN
    // rr_last is maintained in both builds but only consulted with round-robin.
    logic w_unused_rr;
    assign w_unused_rr = r_rr_last;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr_last;
        w_addr_nxt  = r_sdc_addr;
        w_data_nxt  = r_sdc_data;
        w_we_nxt    = r_sdc_we;
        w_start_nxt = r_sdc_start;
        w_iq_nxt    = r_i_q;
        w_dq_nxt    = r_d_q;
        w_idone_nxt = 1'b0;
        w_ddone_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start || d_start) begin
                    w_owner_nxt = w_grant_d;
                    w_addr_nxt  = w_grant_d ? d_addr : i_addr;
                    w_data_nxt  = w_grant_d ? d_data : i_data;
                    w_we_nxt    = w_grant_d ? d_we   : i_we;
                    w_start_nxt = 1'b1;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (sdc_done) begin
                    w_start_nxt = 1'b0;
                    w_addr_nxt  = '0;
                    w_data_nxt  = '0;
                    w_we_nxt    = 1'b0;
                    if (r_owner) begin
                        w_dq_nxt    = sdc_q;
                        w_ddone_nxt = 1'b1;
                    end else begin
                        w_iq_nxt    = sdc_q;
                        w_idone_nxt = 1'b1;
                    end
                    w_rr_nxt    = r_owner;
                    w_state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                // A start still held from the finished transaction must not re-grant.
                if (!(r_owner ? d_start : i_start))
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_owner     <= 1'b0;
            r_rr_last   <= 1'b0;
            r_sdc_addr  <= '0;
            r_sdc_data  <= '0;
            r_sdc_we    <= 1'b0;
            r_sdc_start <= 1'b0;
            r_i_q       <= '0;
            r_d_q       <= '0;
            r_i_done    <= 1'b0;
            r_d_done    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_rr_last   <= w_rr_nxt;
            r_sdc_addr  <= w_addr_nxt;
            r_sdc_data  <= w_data_nxt;
            r_sdc_we    <= w_we_nxt;
            r_sdc_start <= w_start_nxt;
            r_i_q       <= w_iq_nxt;
            r_d_q       <= w_dq_nxt;
            r_i_done    <= w_idone_nxt;
            r_d_done    <= w_ddone_nxt;
        end
    end

    assign sdc_addr  = r_sdc_addr;
    assign sdc_data  = r_sdc_data;
    assign sdc_we    = r_sdc_we;
    assign sdc_start = r_sdc_start;
    assign i_q       = r_i_q;
    assign d_q       = r_d_q;
    assign i_done    = r_i_done;
    assign d_done    = r_d_done;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed self-checking bench for sdram_arbiter; tie-order expectations follow
// SDRAM_ARB_ROUND_ROBIN_EN the same way the design does.
module tb_sdram_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] i_addr, d_addr, sdc_addr;
    logic [DATA_W-1:0] i_data, d_data, sdc_data, i_q, d_q, sdc_q;
    logic              i_we, d_we, i_start, d_start, i_done, d_done;
    logic              sdc_we, sdc_start, sdc_done;

    int n_tests = 0;
    int n_fail  = 0;

    sdram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .i_addr(i_addr), .i_data(i_data), .i_we(i_we), .i_start(i_start),
        .i_q(i_q), .i_done(i_done),
        .d_addr(d_addr), .d_data(d_data), .d_we(d_we), .d_start(d_start),
        .d_q(d_q), .d_done(d_done),
        .sdc_addr(sdc_addr), .sdc_data(sdc_data), .sdc_we(sdc_we),
        .sdc_start(sdc_start), .sdc_q(sdc_q), .sdc_done(sdc_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".sdc_addr"},  64'(sdc_addr),  64'h0);
        check({tag, ".sdc_data"},  64'(sdc_data),  64'h0);
        check({tag, ".sdc_we"},    64'(sdc_we),    64'h0);
        check({tag, ".sdc_start"}, 64'(sdc_start), 64'h0);
        check({tag, ".i_q"},       64'(i_q),       64'h0);
        check({tag, ".d_q"},       64'(d_q),       64'h0);
        check({tag, ".i_done"},    64'(i_done),    64'h0);
        check({tag, ".d_done"},    64'(d_done),    64'h0);
    endtask

    // One transaction from the IDLE grant edge through release; optionally re-raise the owner's start.
    task automatic serve(input string tag, input logic exp_d, input logic [31:0] qv, input logic rereq);
        tick();
        check({tag, ".grant_start"}, 64'(sdc_start), 64'h1);
        check({tag, ".grant_addr"}, 64'(sdc_addr), 64'(exp_d ? d_addr : i_addr));
        sdc_q = qv;
        sdc_done = 1'b1;
        tick();
        sdc_done = 1'b0;
        check({tag, ".i_done"}, 64'(i_done), 64'(!exp_d));
        check({tag, ".d_done"}, 64'(d_done), 64'(exp_d));
        check({tag, ".q"}, 64'(exp_d ? d_q : i_q), 64'(qv));
        if (exp_d) d_start = 1'b0; else i_start = 1'b0;
        tick();
        if (rereq) begin
            if (exp_d) d_start = 1'b1; else i_start = 1'b1;
        end
    endtask

    initial begin
        reset = 1'b1;
        i_addr = '0; i_data = '0; i_we = 1'b0; i_start = 1'b0;
        d_addr = '0; d_data = '0; d_we = 1'b0; d_start = 1'b0;
        sdc_q = '0; sdc_done = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check_all_zero("reset");

        // Single I read
        i_addr = 32'h0000_0123; i_we = 1'b0; i_start = 1'b1;
        tick();
        check("ird.sdc_start", 64'(sdc_start), 64'h1);
        check("ird.sdc_addr",  64'(sdc_addr),  64'h123);
        check("ird.sdc_we",    64'(sdc_we),    64'h0);
        tick();
        check("ird.hold_start", 64'(sdc_start), 64'h1);
        sdc_q = 32'hDEAD_BEEF; sdc_done = 1'b1;
        tick();
        sdc_done = 1'b0;
        check("ird.i_done",    64'(i_done),    64'h1);
        check("ird.i_q",       64'(i_q),       64'hDEAD_BEEF);
        check("ird.d_done",    64'(d_done),    64'h0);
        check("ird.d_q",       64'(d_q),       64'h0);
        check("ird.sdc_start0", 64'(sdc_start), 64'h0);
        check("ird.sdc_addr0", 64'(sdc_addr),  64'h0);
        i_start = 1'b0;
        tick();
        check("ird.done_pulse", 64'(i_done), 64'h0);
        check("ird.i_q_hold",   64'(i_q),    64'hDEAD_BEEF);

        // Single D write, with a requester bus change while BUSY
        d_addr = 32'h0000_0040; d_data = 32'h1234_5678; d_we = 1'b1; d_start = 1'b1;
        tick();
        check("dwr.sdc_addr",  64'(sdc_addr),  64'h40);
        check("dwr.sdc_data",  64'(sdc_data),  64'h1234_5678);
        check("dwr.sdc_we",    64'(sdc_we),    64'h1);
        check("dwr.sdc_start", 64'(sdc_start), 64'h1);
        d_addr = 32'h0000_0999; d_data = 32'hFFFF_0000; d_we = 1'b0;
        tick();
        check("busy.addr_latched", 64'(sdc_addr), 64'h40);
        check("busy.data_latched", 64'(sdc_data), 64'h1234_5678);
        check("busy.we_latched",   64'(sdc_we),   64'h1);
        sdc_q = 32'h0000_0055; sdc_done = 1'b1;
        tick();
        sdc_done = 1'b0;
        check("dwr.d_done", 64'(d_done), 64'h1);
        check("dwr.i_done", 64'(i_done), 64'h0);
        check("dwr.i_q",    64'(i_q),    64'hDEAD_BEEF);
        d_start = 1'b0; d_we = 1'b0;
        tick();

        // Ties from a fresh reset (rr_last = I)
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all_zero("reset2");
        i_addr = 32'h100; d_addr = 32'h200; i_start = 1'b1; d_start = 1'b1;
        serve("tie1", 1'b1, 32'hA1, 1'b1);
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
        serve("tie2", 1'b0, 32'hA2, 1'b1);
`else
        serve("tie2", 1'b1, 32'hA2, 1'b1);
`endif
        serve("tie3", 1'b1, 32'hA3, 1'b0);
        serve("tie4_i", 1'b0, 32'hA4, 1'b0);
        check("tie.idle_start", 64'(sdc_start), 64'h0);

        // Stale start: I held 3 cycles after done with D pending
        i_addr = 32'h300; d_addr = 32'h400; i_start = 1'b1;
        tick();
        check("stale.grant_i", 64'(sdc_addr), 64'h300);
        d_start = 1'b1;
        sdc_q = 32'hB0; sdc_done = 1'b1;
        tick();
        sdc_done = 1'b0;
        check("stale.i_done", 64'(i_done), 64'h1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stale.no_start", 64'(sdc_start), 64'h0);
        end
        i_start = 1'b0;
        tick();
        check("stale.release_low", 64'(sdc_start), 64'h0);
        tick();
        check("stale.grant_d_start", 64'(sdc_start), 64'h1);
        check("stale.grant_d_addr",  64'(sdc_addr),  64'h400);
        sdc_q = 32'hB1; sdc_done = 1'b1;
        tick();
        sdc_done = 1'b0;
        check("stale.d_done", 64'(d_done), 64'h1);
        check("stale.d_q",    64'(d_q),    64'hB1);
        d_start = 1'b0;
        tick();

        // Reset mid-BUSY followed by a spurious sdc_done
        i_addr = 32'h500; i_start = 1'b1;
        tick();
        check("rst.busy_start", 64'(sdc_start), 64'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0; i_start = 1'b0;
        check_all_zero("rst_mid");
        sdc_q = 32'hCC; sdc_done = 1'b1;
        tick();
        sdc_done = 1'b0;
        check_all_zero("spurious");
        tick();
        check("spurious.no_pulse", 64'({i_done, d_done}), 64'h0);
        d_addr = 32'h600; d_start = 1'b1;
        tick();
        check("rst.idle_grant", 64'(sdc_addr), 64'h600);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
